// File: rtl/ttl_mac_rewrite_stage_if.sv
// AXI-Stream bundle for the router output-port-lookup pipeline stages.
// The field names keep the original AXIS suffixes, so that S_AXIS.TDATA reads like S_AXIS_TDATA.
interface ttl_mac_rewrite_stage_if #(
  parameter int DATA_WIDTH = 256,
  parameter int USER_WIDTH = 128
);
  logic [DATA_WIDTH-1:0]   TDATA;
  logic [DATA_WIDTH/8-1:0] TSTRB;
  logic [USER_WIDTH-1:0]   TUSER;
  logic                    TVALID;
  logic                    TREADY;
  logic                    TLAST;

  modport master (output TDATA, TSTRB, TUSER, TVALID, TLAST, input TREADY);
  modport slave  (input TDATA, TSTRB, TUSER, TVALID, TLAST, output TREADY);
endinterface

// File: rtl/ttl_mac_rewrite_stage.sv
// TTL decrement / checksum fix-up / source-MAC rewrite stage with one output register slice.
// Packets whose TTL expires are redirected to the CPU port of their ingress interface.
module ttl_mac_rewrite_stage #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS       = 16,
  parameter int DST_PORT_POS       = 24
) (
  input  logic        AXI_ACLK,
  input  logic        reset,
  ttl_mac_rewrite_stage_if.slave  S_AXIS,
  ttl_mac_rewrite_stage_if.master M_AXIS,
  input  logic [31:0] mac0_low,
  input  logic [31:0] mac0_high,
  input  logic [31:0] mac1_low,
  input  logic [31:0] mac1_high,
  input  logic [31:0] mac2_low,
  input  logic [31:0] mac2_high,
  input  logic [31:0] mac3_low,
  input  logic [31:0] mac3_high,
  input  logic        clear_counters,
  output logic [31:0] fwd_count,
  output logic [31:0] ttl_exp_count,
  output logic [31:0] cpu_pass_count
);

  typedef enum logic {ST_HDR, ST_BODY} state_t;
  typedef enum logic [1:0] {CL_PASS, CL_EXPIRE, CL_FWD} cls_t;

  state_t state_q, state_d;
  cls_t   cls;
  logic   is_hdr;
  logic   accept;

  logic [C_AXIS_DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [C_AXIS_DATA_WIDTH/8-1:0] tstrb_q;
  logic [C_AXIS_TUSER_WIDTH-1:0]  tuser_q, tuser_d;
  logic                           tvalid_q, tlast_q;

  logic [7:0]  dst_bits, src_bits;
  logic [15:0] etype, csum, csum_new;
  logic [7:0]  ttl;
  logic [16:0] sum17;
  logic [47:0] egress_mac;

  // Only the low 16 bits of each high word carry MAC bits.
  logic unused_mac_high;
  assign unused_mac_high = &{1'b0, mac0_high[31:16], mac1_high[31:16],
                             mac2_high[31:16], mac3_high[31:16]};

  assign S_AXIS.TREADY = !tvalid_q || M_AXIS.TREADY;
  assign accept        = S_AXIS.TVALID && S_AXIS.TREADY;

  assign M_AXIS.TDATA  = tdata_q;
  assign M_AXIS.TSTRB  = tstrb_q;
  assign M_AXIS.TUSER  = tuser_q;
  assign M_AXIS.TVALID = tvalid_q;
  assign M_AXIS.TLAST  = tlast_q;

  always_ff @(posedge AXI_ACLK) begin
    if (reset) state_q <= ST_HDR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = S_AXIS.TLAST ? ST_HDR : ST_BODY;
  end

  always_comb begin
    is_hdr = (state_q == ST_HDR);
  end

  always_comb begin
    dst_bits = S_AXIS.TUSER[DST_PORT_POS +: 8];
    src_bits = S_AXIS.TUSER[SRC_PORT_POS +: 8];
    etype    = S_AXIS.TDATA[159:144];
    ttl      = S_AXIS.TDATA[79:72];
    csum     = S_AXIS.TDATA[63:48];

    if ((dst_bits[1] || dst_bits[3] || dst_bits[5] || dst_bits[7]) ||
        !(dst_bits[0] || dst_bits[2] || dst_bits[4] || dst_bits[6]) ||
        (etype != 16'h0800))
      cls = CL_PASS;
    else if (ttl <= 8'd1)
      cls = CL_EXPIRE;
    else
      cls = CL_FWD;

    if (dst_bits[0])      egress_mac = {mac0_high[15:0], mac0_low};
    else if (dst_bits[2]) egress_mac = {mac1_high[15:0], mac1_low};
    else if (dst_bits[4]) egress_mac = {mac2_high[15:0], mac2_low};
    else                  egress_mac = {mac3_high[15:0], mac3_low};

    // Decrementing TTL (high byte of its header word) adds 0x0100 to the ones'-complement checksum.
    sum17    = {1'b0, csum} + 17'h00100;
    csum_new = sum17[15:0] + {15'd0, sum17[16]};

    tdata_d = S_AXIS.TDATA;
    tuser_d = S_AXIS.TUSER;
    if (is_hdr) begin
      case (cls)
        CL_FWD: begin
          tdata_d[79:72]   = ttl - 8'd1;
          tdata_d[63:48]   = csum_new;
          tdata_d[207:160] = egress_mac;
        end
        CL_EXPIRE: begin
          if (src_bits[0])      tuser_d[DST_PORT_POS +: 8] = 8'b0000_0010;
          else if (src_bits[2]) tuser_d[DST_PORT_POS +: 8] = 8'b0000_1000;
          else if (src_bits[4]) tuser_d[DST_PORT_POS +: 8] = 8'b0010_0000;
          else if (src_bits[6]) tuser_d[DST_PORT_POS +: 8] = 8'b1000_0000;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (reset) begin
      tdata_q  <= '0;
      tstrb_q  <= '0;
      tuser_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      if (accept) begin
        tdata_q <= tdata_d;
        tstrb_q <= S_AXIS.TSTRB;
        tuser_q <= tuser_d;
        tlast_q <= S_AXIS.TLAST;
      end
      if (accept)              tvalid_q <= 1'b1;
      else if (M_AXIS.TREADY)  tvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (reset || clear_counters) begin
      fwd_count      <= '0;
      ttl_exp_count  <= '0;
      cpu_pass_count <= '0;
    end else if (accept && is_hdr) begin
      case (cls)
        CL_FWD:    fwd_count      <= fwd_count + 32'd1;
        CL_EXPIRE: ttl_exp_count  <= ttl_exp_count + 32'd1;
        default:   cpu_pass_count <= cpu_pass_count + 32'd1;
      endcase
    end
  end

endmodule

// File: tb/tb_ttl_mac_rewrite_stage.sv
// Directed bench for ttl_mac_rewrite_stage: FWD, checksum carry, EXPIRE, PASS, backpressure, clear and reset.
module tb_ttl_mac_rewrite_stage;

  logic        clk;
  logic        reset;
  logic [31:0] mac0_low, mac0_high, mac1_low, mac1_high;
  logic [31:0] mac2_low, mac2_high, mac3_low, mac3_high;
  logic        clear_counters;
  logic [31:0] fwd_count, ttl_exp_count, cpu_pass_count;

  int n_cmp = 0;
  int n_err = 0;

  ttl_mac_rewrite_stage_if #(.DATA_WIDTH(256), .USER_WIDTH(128)) s_if ();
  ttl_mac_rewrite_stage_if #(.DATA_WIDTH(256), .USER_WIDTH(128)) m_if ();

  ttl_mac_rewrite_stage #(
    .C_AXIS_DATA_WIDTH (256),
    .C_AXIS_TUSER_WIDTH(128),
    .SRC_PORT_POS      (16),
    .DST_PORT_POS      (24)
  ) dut (
    .AXI_ACLK      (clk),
    .reset         (reset),
    .S_AXIS        (s_if),
    .M_AXIS        (m_if),
    .mac0_low      (mac0_low),
    .mac0_high     (mac0_high),
    .mac1_low      (mac1_low),
    .mac1_high     (mac1_high),
    .mac2_low      (mac2_low),
    .mac2_high     (mac2_high),
    .mac3_low      (mac3_low),
    .mac3_high     (mac3_high),
    .clear_counters(clear_counters),
    .fwd_count     (fwd_count),
    .ttl_exp_count (ttl_exp_count),
    .cpu_pass_count(cpu_pass_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [255:0] d, input logic [127:0] u,
                          input logic last, input logic [31:0] strb);
    chk({tag, ".valid"}, {255'd0, m_if.TVALID}, 256'd1);
    chk({tag, ".data"},  m_if.TDATA, d);
    chk({tag, ".user"},  {128'd0, m_if.TUSER}, {128'd0, u});
    chk({tag, ".last"},  {255'd0, m_if.TLAST}, {255'd0, last});
    chk({tag, ".strb"},  {224'd0, m_if.TSTRB}, {224'd0, strb});
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] f, input logic [31:0] e, input logic [31:0] p);
    chk({tag, ".fwd"}, {224'd0, fwd_count}, {224'd0, f});
    chk({tag, ".exp"}, {224'd0, ttl_exp_count}, {224'd0, e});
    chk({tag, ".cpu"}, {224'd0, cpu_pass_count}, {224'd0, p});
  endtask

  function automatic logic [255:0] mk_hdr(input logic [15:0] etype, input logic [7:0] ttl,
                                          input logic [15:0] csum, input logic [255:0] fill);
    logic [255:0] d;
    d = fill;
    d[255:208] = 48'h001122334455;
    d[207:160] = 48'h66778899AABB;
    d[159:144] = etype;
    d[79:72]   = ttl;
    d[71:64]   = 8'h06;
    d[63:48]   = csum;
    return d;
  endfunction

  function automatic logic [127:0] mk_user(input logic [7:0] src, input logic [7:0] dst);
    logic [127:0] u;
    u = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_00A5_5A5A;
    u[23:16] = src;
    u[31:24] = dst;
    return u;
  endfunction

  task automatic send(input logic [255:0] d, input logic [127:0] u, input logic last, input logic [31:0] strb);
    s_if.TDATA  = d;
    s_if.TUSER  = u;
    s_if.TLAST  = last;
    s_if.TSTRB  = strb;
    s_if.TVALID = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_if.TVALID = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [255:0] d0, d1, d2, d3, e0;
  logic [127:0] u0, u1, ue;
  localparam logic [255:0] FILL_A = {8{32'h5EED_1234}};
  localparam logic [255:0] FILL_B = {8{32'hA1B2_C3D4}};

  initial begin
    reset = 1'b1;
    clear_counters = 1'b0;
    s_if.TVALID = 1'b0;
    s_if.TDATA = '0;
    s_if.TUSER = '0;
    s_if.TSTRB = '0;
    s_if.TLAST = 1'b0;
    m_if.TREADY = 1'b1;
    mac0_low = 32'h1C1D1E1F; mac0_high = 32'hDEAD1A1B;
    mac1_low = 32'h0C0D0E0F; mac1_high = 32'h00000A0B;
    mac2_low = 32'h2C2D2E2F; mac2_high = 32'h00002A2B;
    mac3_low = 32'h3C3D3E3F; mac3_high = 32'hFFFF3A3B;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", {255'd0, m_if.TVALID}, 256'd0);
    chk("rst.data", m_if.TDATA, 256'd0);
    chk("rst.user", {128'd0, m_if.TUSER}, 256'd0);
    chk_cnt("rst", 0, 0, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single-beat FWD through port 2 -> mac1
    d0 = mk_hdr(16'h0800, 8'h40, 16'hB1E6, FILL_A);
    u0 = mk_user(8'b0000_0001, 8'b0000_0100);
    e0 = d0;
    e0[79:72] = 8'h3F; e0[63:48] = 16'hB2E6; e0[207:160] = 48'h0A0B0C0D0E0F;
    chk("fwd.pre_valid", {255'd0, m_if.TVALID}, 256'd0);
    send(d0, u0, 1'b1, 32'hFFFF_FFFF);
    chk_beat("fwd", e0, u0, 1'b1, 32'hFFFF_FFFF);
    chk_cnt("fwd", 1, 0, 0);
    idle();
    chk("fwd.drain", {255'd0, m_if.TVALID}, 256'd0);

    // Checksum end-around carry; ports 0 and 4 set -> lowest wins (mac0)
    d0 = mk_hdr(16'h0800, 8'h02, 16'hFF80, FILL_B);
    u0 = mk_user(8'b0000_0100, 8'b0001_0001);
    e0 = d0;
    e0[79:72] = 8'h01; e0[63:48] = 16'h0081; e0[207:160] = 48'h1A1B1C1D1E1F;
    send(d0, u0, 1'b1, 32'h0000_FFFF);
    chk_beat("carry", e0, u0, 1'b1, 32'h0000_FFFF);
    chk_cnt("carry", 2, 0, 0);

    // EXPIRE: TTL 1, ingress port 4 -> CPU port 5
    d0 = mk_hdr(16'h0800, 8'h01, 16'h4321, FILL_A);
    u0 = mk_user(8'b0001_0000, 8'b0000_0001);
    ue = u0;
    ue[31:24] = 8'b0010_0000;
    send(d0, u0, 1'b1, 32'hFFFF_FFFF);
    chk_beat("expire", d0, ue, 1'b1, 32'hFFFF_FFFF);
    chk_cnt("expire", 2, 1, 0);

    // PASS: 3-beat ARP to CPU port 1, back-to-back
    d0 = mk_hdr(16'h0806, 8'h40, 16'hB1E6, FILL_A);
    d1 = FILL_B;
    d2 = mk_hdr(16'h0800, 8'h40, 16'h1111, FILL_A);
    u0 = mk_user(8'b0000_0001, 8'b0000_0010);
    send(d0, u0, 1'b0, 32'hFFFF_FFFF);
    chk_beat("pass.b0", d0, u0, 1'b0, 32'hFFFF_FFFF);
    send(d1, u0, 1'b0, 32'hFFFF_FFFF);
    chk_beat("pass.b1", d1, u0, 1'b0, 32'hFFFF_FFFF);
    send(d2, u0, 1'b1, 32'h0000_00FF);
    chk_beat("pass.b2", d2, u0, 1'b1, 32'h0000_00FF);
    chk_cnt("pass", 2, 1, 1);

    // 2-beat FWD to port 6 -> mac3; the second beat looks like a header but must pass untouched
    d0 = mk_hdr(16'h0800, 8'h80, 16'h1234, FILL_B);
    d1 = mk_hdr(16'h0800, 8'h40, 16'hB1E6, FILL_A);
    u0 = mk_user(8'b0000_0001, 8'b0100_0000);
    e0 = d0;
    e0[79:72] = 8'h7F; e0[63:48] = 16'h1334; e0[207:160] = 48'h3A3B3C3D3E3F;
    send(d0, u0, 1'b0, 32'hFFFF_FFFF);
    chk_beat("fwd2.b0", e0, u0, 1'b0, 32'hFFFF_FFFF);
    send(d1, u0, 1'b1, 32'hFFFF_FFFF);
    chk_beat("fwd2.b1", d1, u0, 1'b1, 32'hFFFF_FFFF);
    chk_cnt("fwd2", 3, 1, 1);

    // Backpressure: 4-beat packet to CPU port 3 (odd bit wins over IPv4 ethertype)
    d0 = mk_hdr(16'h0800, 8'h40, 16'hB1E6, FILL_A);
    d1 = FILL_B;
    d2 = ~FILL_A;
    d3 = ~FILL_B;
    u1 = mk_user(8'b0000_0001, 8'b0000_1001);
    send(d0, u1, 1'b0, 32'hFFFF_FFFF);
    chk_beat("bp.b0", d0, u1, 1'b0, 32'hFFFF_FFFF);
    m_if.TREADY = 1'b0;
    s_if.TDATA = d1;
    s_if.TLAST = 1'b0;
    #1;
    chk("bp.s_ready_low", {255'd0, s_if.TREADY}, 256'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp.s_ready_hold", {255'd0, s_if.TREADY}, 256'd0);
      chk_beat("bp.hold", d0, u1, 1'b0, 32'hFFFF_FFFF);
    end
    m_if.TREADY = 1'b1;
    send(d1, u1, 1'b0, 32'hFFFF_FFFF);
    chk_beat("bp.b1", d1, u1, 1'b0, 32'hFFFF_FFFF);
    send(d2, u1, 1'b0, 32'hFFFF_FFFF);
    chk_beat("bp.b2", d2, u1, 1'b0, 32'hFFFF_FFFF);
    send(d3, u1, 1'b1, 32'h0000_000F);
    chk_beat("bp.b3", d3, u1, 1'b1, 32'h0000_000F);
    chk_cnt("bp", 3, 1, 2);
    idle();
    chk("bp.drain", {255'd0, m_if.TVALID}, 256'd0);

    // clear_counters coincident with a FWD header accept
    d0 = mk_hdr(16'h0800, 8'h40, 16'hB1E6, FILL_A);
    u0 = mk_user(8'b0000_0001, 8'b0000_0100);
    e0 = d0;
    e0[79:72] = 8'h3F; e0[63:48] = 16'hB2E6; e0[207:160] = 48'h0A0B0C0D0E0F;
    clear_counters = 1'b1;
    send(d0, u0, 1'b1, 32'hFFFF_FFFF);
    clear_counters = 1'b0;
    chk_beat("clr", e0, u0, 1'b1, 32'hFFFF_FFFF);
    chk_cnt("clr", 0, 0, 0);

    // Reset mid-packet, then the next beat is a header again
    send(d0, u0, 1'b0, 32'hFFFF_FFFF);
    chk_cnt("mid.pre", 1, 0, 0);
    s_if.TDATA = mk_hdr(16'h0800, 8'h40, 16'hB1E6, FILL_B);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid.valid", {255'd0, m_if.TVALID}, 256'd0);
    chk("mid.data", m_if.TDATA, 256'd0);
    chk("mid.user", {128'd0, m_if.TUSER}, 256'd0);
    chk_cnt("mid", 0, 0, 0);
    reset = 1'b0;
    d1 = mk_hdr(16'h0800, 8'h40, 16'hB1E6, FILL_B);
    e0 = d1;
    e0[79:72] = 8'h3F; e0[63:48] = 16'hB2E6; e0[207:160] = 48'h0A0B0C0D0E0F;
    send(d1, u0, 1'b1, 32'hFFFF_FFFF);
    chk_beat("post", e0, u0, 1'b1, 32'hFFFF_FFFF);
    chk_cnt("post", 1, 0, 0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
